// File: rtl/fb_arbiter.sv
// Framebuffer arbiter: frame sequencing FSM (IDLE/RENDER/DUMP) plus a one-access-per-cycle
// grant of a single-port synchronous RAM between the VGA scanner, the renderer and the dump reader.
module fb_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int PIX_W    = 3,
    parameter int FB_DEPTH = 19200,
    parameter int DUMP_EN  = 1
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              frame_tick,
    input  logic              render_done,
    input  logic              dump_done,
    output logic              render_go,
    output logic              dump_go,
    input  logic              v_req,
    input  logic [ADDR_W-1:0] v_addr,
    output logic [PIX_W-1:0]  v_rdata,
    output logic              v_valid,
    input  logic              r_req,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic [PIX_W-1:0]  r_wdata,
    output logic              r_ack,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_ack,
    output logic [PIX_W-1:0]  d_rdata,
    output logic              d_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [PIX_W-1:0]  mem_wdata,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [1:0]        state,
    output logic [7:0]        overrun_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RENDER = 2'd1,
        DUMP   = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(FB_DEPTH);

    state_t            cur;
    logic              g_v, g_r, g_d, any_grant, in_range;
    logic [ADDR_W-1:0] sel_addr, last_addr;
    logic              pend_v, pend_d, pend_oob;

    assign state = cur;

    // VGA never stalls; the other two ports only get the RAM in their own phase.
    assign g_v       = v_req;
    assign g_r       = !v_req && r_req && (cur == RENDER);
    assign g_d       = !v_req && d_req && (cur == DUMP);
    assign any_grant = g_v || g_r || g_d;
    assign r_ack     = g_r;
    assign d_ack     = g_d;

    always_comb begin
        sel_addr = last_addr;
        if (g_v)
            sel_addr = v_addr;
        else if (g_r)
            sel_addr = r_addr;
        else if (g_d)
            sel_addr = d_addr;
    end

    assign in_range  = {1'b0, sel_addr} < DEPTH;
    assign mem_addr  = sel_addr;
    assign mem_we    = g_r && in_range;
    assign mem_wdata = g_r ? r_wdata : '0;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cur         <= IDLE;
            render_go   <= 1'b0;
            dump_go     <= 1'b0;
            overrun_cnt <= 8'd0;
        end else begin
            render_go <= 1'b0;
            dump_go   <= 1'b0;
            if (frame_tick && cur != IDLE && overrun_cnt != 8'd255)
                overrun_cnt <= overrun_cnt + 8'd1;
            case (cur)
                IDLE: if (frame_tick) begin
                    cur       <= RENDER;
                    render_go <= 1'b1;
                end
                RENDER: if (render_done) begin
                    if (DUMP_EN != 0) begin
                        cur     <= DUMP;
                        dump_go <= 1'b1;
                    end else begin
                        cur <= IDLE;
                    end
                end
                DUMP: if (dump_done) cur <= IDLE;
                default: cur <= IDLE;
            endcase
        end
    end

    // Stage 1 remembers which port owns the read the RAM is performing; stage 2 captures its data.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            last_addr <= '0;
            pend_v    <= 1'b0;
            pend_d    <= 1'b0;
            pend_oob  <= 1'b0;
            v_valid   <= 1'b0;
            d_valid   <= 1'b0;
            v_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            if (any_grant)
                last_addr <= sel_addr;
            pend_v   <= g_v;
            pend_d   <= g_d;
            pend_oob <= !in_range;
            v_valid  <= pend_v;
            d_valid  <= pend_d;
            if (pend_v)
                v_rdata <= pend_oob ? '0 : mem_rdata;
            if (pend_d)
                d_rdata <= pend_oob ? '0 : mem_rdata;
        end
    end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16: framebuffer address width.
REQ-002 Parameter PIX_W, default 3: pixel colour-code width.
REQ-003 Parameter FB_DEPTH, default 19200: number of valid framebuffer locations (160x120).
REQ-004 Parameter DUMP_EN, default 1: 1 enables the DUMP state; 0 skips it.
REQ-005 Ports:
- clk  in  1: single clock; all logic on rising edge.
- clr_n  in  1: reset, synchronous, active-low.
- frame_tick  in  1: one-cycle pulse at frame start (vsync).
- render_done  in  1: one-cycle pulse from the renderer at the end of a frame write.
- dump_done  in  1: one-cycle pulse from the dump reader at the end of a frame read.
- render_go  out  1: one-cycle pulse that starts the renderer.
- dump_go  out  1: one-cycle pulse that starts the dump reader.
- v_req  in  1, v_addr  in  ADDR_W: VGA scan read request.
- v_rdata  out  PIX_W, v_valid  out  1: VGA read data and its strobe.
- r_req  in  1, r_addr  in  ADDR_W, r_wdata  in  PIX_W: renderer write request.
- r_ack  out  1: renderer write accepted this cycle.
- d_req  in  1, d_addr  in  ADDR_W: dump read request.
- d_ack  out  1: dump read accepted this cycle.
- d_rdata  out  PIX_W, d_valid  out  1: dump read data and its strobe.
- mem_addr  out  ADDR_W, mem_we  out  1, mem_wdata  out  PIX_W: single-port synchronous RAM control.
- mem_rdata  in  PIX_W: RAM read data, valid the cycle after the address edge.
- state  out  2: 0=IDLE, 1=RENDER, 2=DUMP.
- overrun_cnt  out  8: count of frame_tick pulses not accepted in IDLE.

Function
REQ-006 The FSM SHALL implement IDLE->RENDER on frame_tick, asserting render_go for exactly that transition cycle.
REQ-007 RENDER->DUMP on render_done when DUMP_EN=1, asserting dump_go once; RENDER->IDLE on render_done when DUMP_EN=0.
REQ-008 DUMP->IDLE on dump_done; dump_done outside DUMP, and render_done outside RENDER, SHALL be ignored.
REQ-009 A frame_tick arriving in RENDER or DUMP SHALL increment overrun_cnt (saturating at 255) and SHALL NOT change state.
REQ-010 frame_tick together with render_done in RENDER: take the render_done transition and count an overrun.
REQ-011 Grant (combinational, one access per cycle): v_req always wins; otherwise r_req is granted only in RENDER; otherwise d_req is granted only in DUMP.
REQ-012 r_ack/d_ack SHALL equal the grant; a requester that is not acked holds its request; the VGA port has no ack and is never stalled.
REQ-013 mem_addr, mem_we and mem_wdata SHALL be driven from the granted port; with no grant: mem_we=0 and mem_addr holds its last value.
REQ-014 Read latency: for a read granted at edge E0, the arbiter SHALL register mem_rdata at E1 and pulse x_valid for one cycle after E1; x_rdata holds until the next valid.
REQ-015 Address >= FB_DEPTH: writes are acked, mem_we=0 (dropped); reads are granted, return rdata=0 with a normal valid pulse.
REQ-016 Back-to-back reads SHALL be fully pipelined: one valid per granted cycle, in grant order per port.

Reset
REQ-017 When clr_n=0 at an edge: state=IDLE; overrun_cnt=0; render_go, dump_go, v_valid and d_valid=0; v_rdata and d_rdata=0; mem_we=0; mem_addr=0.
REQ-018 Reads in flight at reset SHALL be discarded, with no valid after reset release; the first frame_tick after release starts RENDER.

Verification
REQ-019 Reset, then frame_tick -> render_go pulses once, state=1; render_done -> dump_go pulses, state=2; dump_done -> state=0.
REQ-020 In RENDER, v_req=1 with v_addr=5 and r_req=1 with r_addr=7, r_wdata=3 in the same cycle -> r_ack=0, mem_addr=5; next cycle (v_req=0) -> r_ack=1, mem_we=1, mem_addr=7, mem_wdata=3.
REQ-021 Preload addr 9=6; in DUMP, d_req with d_addr=9 acked at E0 -> d_valid=1 with d_rdata=6 in the cycle after E1 only.
REQ-022 r_addr=19200 in RENDER -> r_ack=1, mem_we=0; d_addr=19200 in DUMP -> d_rdata=0 with valid.
REQ-023 Three frame_ticks during RENDER -> overrun_cnt=3; 300 ticks -> overrun_cnt=255; r_req in IDLE -> r_ack=0.
REQ-024 clr_n=0 one cycle after a v read is granted -> no v_valid; all outputs at their reset values.
